seg_scan_mux: RTL

Time-multiplexed scanner for a multi-digit common-anode seven-segment display. It sits directly upstream of the hex-to-segment decoder: each cycle it presents that decoder with the current digit's nibble, and it drives the active-low digit anodes and decimal point itself. New display values are taken through a load/pending handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits. A dead-time blank at the start of each digit slot prevents ghosting.

---
 rtl/seg_scan_mux_if.sv | 29 ++
 rtl/seg_scan_mux.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seg_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux_if
// Brief    : Load handshake and display drive bundle for seg_scan_mux.
// Revision : 1.0
// ============================================================================
interface seg_scan_mux_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] data_in;
   logic [DIGITS-1:0]   dp_in;
   logic                load;
   logic                pending;
   logic [7:0]          nibble;
   logic                dp_n;
   logic [DIGITS-1:0]   an_n;
   logic                frame_start;

   modport master (
      output data_in, dp_in, load,
      input  pending, nibble, dp_n, an_n, frame_start
   );

   modport slave (
      input  data_in, dp_in, load,
      output pending, nibble, dp_n, an_n, frame_start
   );
endinterface
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Brief    : Multiplexed common-anode 7-seg scanner with frame-aligned commit.
//            Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
// Revision : 1.0
// ============================================================================
module seg_scan_mux #(
   parameter int DIGITS       = 4,
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic         clk,
   input  logic         rst,
   seg_scan_mux_if.slave bus
);
   localparam int c_cw = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int c_iw = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [c_cw-1:0]   c_cnt_max = c_cw'(SLOT_CYCLES - 1);
   localparam logic [c_iw-1:0]   c_idx_max = c_iw'(DIGITS - 1);
   localparam logic [c_cw-1:0]   c_blank   = c_cw'(BLANK_CYCLES);
   localparam logic [DIGITS-1:0] c_an_one  = DIGITS'(1);

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } phase_t;

   localparam phase_t c_phase_rst = (BLANK_CYCLES > 0) ? ST_BLANK : ST_ON;

   logic [c_cw-1:0]     r_cnt;
   logic [c_iw-1:0]     r_idx;
   phase_t              r_state;
   logic [4*DIGITS-1:0] r_shadow;
   logic [DIGITS-1:0]   r_shadow_dp;
   logic [4*DIGITS-1:0] r_stage;
   logic [DIGITS-1:0]   r_stage_dp;
   logic                r_pending;
   logic [7:0]          r_nibble;
   logic                r_dp_n;
   logic [DIGITS-1:0]   r_an_n;
   logic                r_frame_start;

   logic                w_cnt_last;
   logic                w_bound;
   logic [c_cw-1:0]     w_cnt_nxt;
   logic [c_iw-1:0]     w_idx_nxt;
   phase_t              w_state_nxt;
   logic [DIGITS-1:0]   w_an_nxt;
   logic [3:0]          w_digit;
   logic [DIGITS-1:0]   w_supp;

`ifdef LEADING_ZERO_BLANK_EN
   logic w_zero_above;

   // Walk from the most significant digit down; a digit is blanked only while
   // everything at and above it is zero and its own decimal point is off.
   always_comb begin
      w_zero_above = 1'b1;
      w_supp       = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         w_zero_above = w_zero_above & (r_shadow[4*k +: 4] == 4'h0);
         w_supp[k]    = w_zero_above & ~r_shadow_dp[k];
      end
   end
`else
   assign w_supp = '0;
`endif

   always_comb begin
      w_cnt_last  = (r_cnt == c_cnt_max);
      w_bound     = w_cnt_last && (r_idx == c_idx_max);
      w_cnt_nxt   = w_cnt_last ? '0 : r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      if (w_cnt_last) begin
         w_idx_nxt = (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
      end
      w_state_nxt = (w_cnt_nxt < c_blank) ? ST_BLANK : ST_ON;
      w_an_nxt    = '1;
      if ((r_state == ST_ON) && !w_supp[r_idx]) begin
         w_an_nxt = ~(c_an_one << r_idx);
      end
      w_digit     = r_shadow[{r_idx, 2'b00} +: 4];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_phase_rst;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt         <= '0;
         r_idx         <= '0;
         r_shadow      <= '0;
         r_shadow_dp   <= '0;
         r_stage       <= '0;
         r_stage_dp    <= '0;
         r_pending     <= 1'b0;
         r_nibble      <= 8'h00;
         r_dp_n        <= 1'b1;
         r_an_n        <= '1;
         r_frame_start <= 1'b0;
      end else begin
         r_cnt         <= w_cnt_nxt;
         r_idx         <= w_idx_nxt;
         r_nibble      <= {4'h0, w_digit};
         r_dp_n        <= ~r_shadow_dp[r_idx];
         r_an_n        <= w_an_nxt;
         r_frame_start <= (r_cnt == '0) && (r_idx == '0);
         // A load landing on the boundary bypasses staging entirely.
         if (w_bound) begin
            r_pending <= 1'b0;
            if (bus.load) begin
               r_shadow    <= bus.data_in;
               r_shadow_dp <= bus.dp_in;
            end else if (r_pending) begin
               r_shadow    <= r_stage;
               r_shadow_dp <= r_stage_dp;
            end
         end else if (bus.load) begin
            r_stage    <= bus.data_in;
            r_stage_dp <= bus.dp_in;
            r_pending  <= 1'b1;
         end
      end
   end

   assign bus.pending     = r_pending;
   assign bus.nibble      = r_nibble;
   assign bus.dp_n        = r_dp_n;
   assign bus.an_n        = r_an_n;
   assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire
